cr_clic_int_hold: RTL

Downstream stage of the CLIC arbiter. It takes the combinational arbitration winner (id, level, hv, mode) and qualifies it against the machine threshold and the core's current interrupt level. It registers a stable request to the core and runs the request/ack handshake. When the core takes the interrupt, it issues a one-cycle pending-clear to the per-interrupt kid logic, then blanks requests for a settle window so a stale winner is never re-presented.

---
 rtl/cr_clic_int_hold.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cr_clic_int_hold.sv
`default_nettype none
// ============================================================================
// Module   : cr_clic_int_hold
// Purpose  : Qualifies the CLIC arbitration winner against the threshold and
//            the current core level. Holds a stable request to the core,
//            runs the request/ack handshake, pulses a pending-clear and then
//            blanks new requests for a settle window.
// Revision : 1.0 - initial release
// ============================================================================
module cr_clic_int_hold #(
  parameter int ID_WIDTH   = 12,
  parameter int IL_WIDTH   = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic                out_clk,
  input  logic                cpurst_b,
  input  logic                arb_ctrl_int_hv,
  input  logic [ID_WIDTH-1:0] arb_ctrl_int_id,
  input  logic [IL_WIDTH-1:0] arb_ctrl_int_il,
  input  logic                arb_ctrl_int_mode,
  input  logic [IL_WIDTH-1:0] ctrl_mintthresh,
  input  logic [IL_WIDTH-1:0] cpu_clic_cur_il,
  input  logic                cpu_clic_int_ack,
  output logic                clic_cpu_int_req,
  output logic [ID_WIDTH-1:0] clic_cpu_int_id,
  output logic [IL_WIDTH-1:0] clic_cpu_int_il,
  output logic                clic_cpu_int_hv,
  output logic                clic_cpu_int_mode,
  output logic                ctrl_kid_clr_vld,
  output logic [ID_WIDTH-1:0] ctrl_kid_clr_id,
  output logic                out_clk_en
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_CLR    = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  // Counter value loaded on leaving CLR; the settle window ends when it
  // would step down to zero.
  localparam logic [2:0] c_settle_load = 3'(SETTLE_CYC - 1);

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [IL_WIDTH-1:0]   il_q, il_d;
  logic                  hv_q, hv_d;
  logic                  mode_q, mode_d;
  logic [ID_WIDTH-1:0]   clr_id_q, clr_id_d;
  logic                  w_eligible;

  // Winner must be a real request strictly above both threshold and current level.
  always_comb begin
    w_eligible = (arb_ctrl_int_il != '0)
              && (arb_ctrl_int_il > ctrl_mintthresh)
              && (arb_ctrl_int_il > cpu_clic_cur_il);
  end

  // Next-state and hold-register update; ack takes priority over recapture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    il_d     = il_q;
    hv_d     = hv_q;
    mode_d   = mode_q;
    clr_id_d = clr_id_q;
    case (state_q)
      ST_IDLE: begin
        if (w_eligible) begin
          id_d    = arb_ctrl_int_id;
          il_d    = arb_ctrl_int_il;
          hv_d    = arb_ctrl_int_hv;
          mode_d  = arb_ctrl_int_mode;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (cpu_clic_int_ack) begin
          clr_id_d = id_q;
          state_d  = ST_CLR;
        end else if (w_eligible) begin
          id_d   = arb_ctrl_int_id;
          il_d   = arb_ctrl_int_il;
          hv_d   = arb_ctrl_int_hv;
          mode_d = arb_ctrl_int_mode;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLR: begin
        cnt_d = c_settle_load;
        if (c_settle_load == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State and held data registers; reset takes effect immediately.
  always_ff @(posedge out_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      id_q     <= '0;
      il_q     <= '0;
      hv_q     <= 1'b0;
      mode_q   <= 1'b0;
      clr_id_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      il_q     <= il_d;
      hv_q     <= hv_d;
      mode_q   <= mode_d;
      clr_id_q <= clr_id_d;
    end
  end

  // Outputs are decoded from registered state only, except the clock enable
  // which must wake the domain as soon as an eligible winner appears.
  always_comb begin
    clic_cpu_int_req  = (state_q == ST_REQ);
    clic_cpu_int_id   = id_q;
    clic_cpu_int_il   = il_q;
    clic_cpu_int_hv   = hv_q;
    clic_cpu_int_mode = mode_q;
    ctrl_kid_clr_vld  = (state_q == ST_CLR);
    ctrl_kid_clr_id   = clr_id_q;
    out_clk_en        = (state_q != ST_IDLE) || w_eligible;
  end

endmodule
`default_nettype wire
